// File: rtl/seq_det_scheduler.sv
// Time-shares one serial sequence detector among N word requesters and reports per-word hit counts.
// Build option: define SEQ_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration (no round-robin pointer).
module seq_det_scheduler #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int DET_LAT = 1,
    parameter int IDW     = $clog2(N),
    parameter int CW      = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    output logic             det_reset,
    output logic             det_valid,
    output logic             det_bit,
    input  logic             det_hit,
    output logic             res_valid,
    output logic [IDW-1:0]   res_id,
    output logic [CW-1:0]    res_count
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;

    localparam int BCW = (W > 1) ? $clog2(W) : 1;
    localparam int DCW = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;
    localparam logic [IDW:0]   NUM_REQ  = (IDW + 1)'(N);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);
    localparam logic [DCW-1:0] LAST_DRN = DCW'(DET_LAT - 1);

    // Requester index following idx, wrapping at N-1.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
        logic [IDW-1:0] nxt;
        if (idx == IDW'(N - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + IDW'(1);
        end
        return nxt;
    endfunction

    logic [2:0]         state_r;
    logic [W-1:0]       shreg_r;
    logic [BCW-1:0]     bit_cnt_r;
    logic [DCW-1:0]     drain_cnt_r;
    logic [DET_LAT-1:0] tag_r;
    logic [DET_LAT-1:0] tag_next_s;
    logic [CW-1:0]      count_r;
    logic [IDW-1:0]     id_r;
    logic               det_reset_r;
    logic               det_valid_r;
    logic               det_bit_r;
    logic               res_valid_r;
`ifndef SEQ_SCHED_FIXED_PRIO_EN
    logic [IDW-1:0]     rr_ptr_r;
`endif

    logic [IDW-1:0]     grant_idx_s;
    logic               grant_found_s;
    logic [IDW:0]       cand_s;
    logic               accept_s;

    // Arbitration: scan candidates starting at the pointer (or at index 0 in fixed priority).
    always_comb begin
        grant_idx_s   = '0;
        grant_found_s = 1'b0;
        cand_s        = '0;
        for (int i = 0; i < N; i++) begin
`ifdef SEQ_SCHED_FIXED_PRIO_EN
            cand_s = (IDW + 1)'(i);
`else
            cand_s = {1'b0, rr_ptr_r} + (IDW + 1)'(i);
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
`endif
            if (!grant_found_s && req_valid[cand_s[IDW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[IDW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Acceptance is offered only in IDLE and never while reset is held.
    always_comb begin
        accept_s  = (state_r == ST_IDLE) && grant_found_s && !reset;
        req_ready = '0;
        if (accept_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Tag pipeline next value: bit 0 marks a cycle that presented a word bit.
    always_comb begin
        tag_next_s    = tag_r << 1;
        tag_next_s[0] = det_valid_r;
    end

    // Main controller: state, serializer, counters and registered detector/result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            shreg_r     <= '0;
            bit_cnt_r   <= '0;
            drain_cnt_r <= '0;
            tag_r       <= '0;
            count_r     <= '0;
            id_r        <= '0;
            det_reset_r <= 1'b0;
            det_valid_r <= 1'b0;
            det_bit_r   <= 1'b0;
            res_valid_r <= 1'b0;
`ifndef SEQ_SCHED_FIXED_PRIO_EN
            rr_ptr_r    <= '0;
`endif
        end else begin
            tag_r <= tag_next_s;
            // Only hits aligned with a presented word bit are counted.
            if (tag_r[DET_LAT-1] && det_hit) begin
                count_r <= count_r + CW'(1);
            end else begin
                count_r <= count_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shreg_r     <= req_data[int'(grant_idx_s) * W +: W];
                        id_r        <= grant_idx_s;
                        count_r     <= '0;
                        det_reset_r <= 1'b1;
                        state_r     <= ST_CLEAR;
`ifndef SEQ_SCHED_FIXED_PRIO_EN
                        rr_ptr_r    <= wrap_inc(grant_idx_s);
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    det_reset_r <= 1'b0;
                    det_valid_r <= 1'b1;
                    det_bit_r   <= shreg_r[W-1];
                    shreg_r     <= shreg_r << 1;
                    bit_cnt_r   <= '0;
                    state_r     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        det_valid_r <= 1'b0;
                        det_bit_r   <= 1'b0;
                        drain_cnt_r <= '0;
                        state_r     <= ST_DRAIN;
                    end else begin
                        det_bit_r <= shreg_r[W-1];
                        shreg_r   <= shreg_r << 1;
                        bit_cnt_r <= bit_cnt_r + BCW'(1);
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == LAST_DRN) begin
                        res_valid_r <= 1'b1;
                        state_r     <= ST_REPORT;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DCW'(1);
                        state_r     <= ST_DRAIN;
                    end
                end
                ST_REPORT: begin
                    res_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    det_reset_r <= 1'b0;
                    det_valid_r <= 1'b0;
                    det_bit_r   <= 1'b0;
                    res_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign det_reset = det_reset_r;
    assign det_valid = det_valid_r;
    assign det_bit   = det_bit_r;
    assign res_valid = res_valid_r;
    assign res_id    = id_r;
    assign res_count = count_r;

endmodule

// File: doc/seq_det_scheduler.md
# seq_det_scheduler

Controller that time-shares one serial sequence detector (`valid`/`bit_in` in, Moore `bit_out` out) among N parallel-word requesters. It grants one requester, clears the detector, serializes the granted word MSB-first into it, counts detector hits over that word, and reports the count tagged with the requester ID. Sits between the requester-side word interfaces and the single detector instance.

## Interface
- `N`, 4, number of requesters (≥2)
- `W`, 8, word width in bits (≥2)
- `DET_LAT`, 1, cycles from a bit being presented (`det_valid`=1 at an edge) to the detector's `bit_out` reflecting it
- `IDW`, $clog2(N), requester ID width
- `CW`, $clog2(W+1), hit-count width

- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  N  per-requester word available
- `req_data`  in  N*W  word for requester i at bits [i*W +: W]
- `req_ready`  out  N  one-hot acceptance; transfer when `req_valid[i] & req_ready[i]`
- `det_reset`  out  1  one-cycle clear pulse to the detector
- `det_valid`  out  1  drives detector `valid`
- `det_bit`  out  1  drives detector `bit_in`
- `det_hit`  in  1  detector `bit_out`
- `res_valid`  out  1  one-cycle result strobe
- `res_id`  out  IDW  requester whose word produced the result
- `res_count`  out  CW  number of hits counted for the word

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, REPORT.
- IDLE: if any `req_valid`, select grant g (round-robin: first valid index at or after `rr_ptr`, wrapping); `req_ready[g]`=1 combinationally this cycle only. On the edge: latch `req_data[g]` into shift register, latch `res_id`=g, `rr_ptr`=(g+1) mod N, clear count, → CLEAR. No valid → stay.
- CLEAR: `det_reset`=1, `det_valid`=0 → SHIFT.
- SHIFT: `det_valid`=1, `det_bit`=shreg[W-1]; shreg shifts left each edge; bit counter 0..W-1; after bit W-1 → DRAIN.
- DRAIN: `det_valid`=0 for DET_LAT cycles → REPORT.
- REPORT: `res_valid`=1, `res_id`/`res_count` valid; → IDLE.
- Hit counting: a DET_LAT-deep tag pipeline records which cycles presented a word bit; `det_hit` is added to the count only in cycles where the tag emerging from the pipeline is 1. Hits at any other time (CLEAR, IDLE, stale) are ignored. Count never exceeds W; no saturation logic.
- `req_ready` is 0 in every state except IDLE; non-granted requesters wait with `req_valid` and `req_data` held.
- `req_data` is sampled only on the accept edge; later changes do not affect the word in flight.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `req_ready`=0, `det_reset`=0, `det_valid`=0, `det_bit`=0, `res_valid`=0, `res_id`=0, `res_count`=0, shreg=0, tag pipeline=0.
- Reset asserted in any state aborts the word: no `res_valid` for it; next edge all outputs at reset values.
- Accept edge = edge 0. CLEAR in cycle 1, bits in cycles 2..W+1, DRAIN cycles W+2..W+DET_LAT+1, `res_valid` in cycle W+DET_LAT+2.
- IDLE follows REPORT; a pending request is accepted in that IDLE cycle, so back-to-back accepts are spaced W+DET_LAT+3 cycles (12 at defaults).
- Simultaneous requests: resolved by the arbitration rule in the same IDLE cycle; exactly one `req_ready` bit high.

## Configuration
- `SEQ_SCHED_FIXED_PRIO_EN` defined: fixed priority, lowest valid index always wins; `rr_ptr` not implemented.
- Undefined (default): round-robin as in Operation.

## Test plan
Bench uses a detector stub asserting `det_hit` DET_LAT cycles after each presented bit equal to 1 (count = popcount). N=4, W=8, DET_LAT=1.
- Single req0, data 8'hB6 → `req_ready`=4'b0001 for one cycle; `det_reset` pulse cycle 1; `det_bit` 1,0,1,1,0,1,1,0 in cycles 2..9; `res_valid` at cycle 11, `res_id`=0, `res_count`=5.
- All four valid after reset with 8'hFF, 8'h00, 8'h0F, 8'h81 → grants 0,1,2,3, results counts 8,0,4,2, accepts 12 cycles apart.
- req1 and req3 held valid continuously → grants alternate 1,3,1,3; no starvation.
- Reset pulsed during SHIFT bit 4 → following cycle all outputs zero, no result for that word; first post-reset grant from `rr_ptr`=0.
- Stub asserts `det_hit` during CLEAR and IDLE → not counted; `res_count` equals popcount only.
- `SEQ_SCHED_FIXED_PRIO_EN` defined, req0 and req2 held valid → req2 never granted while req0 valid; granted once req0 drops.
